// File: rtl/tetris_pkg.sv
// Shared definitions for the falling-piece controller.
// Holds pose field widths, keyboard action codes, the controller state enum
// and the packed pose payload carried between the controller and the board.
package tetris_pkg;

  localparam int unsigned X_W     = 4;
  localparam int unsigned Y_W     = 5;
  localparam int unsigned ROT_W   = 2;
  localparam int unsigned SHAPE_W = 3;
  localparam int unsigned KEY_W   = 16;

  localparam logic [KEY_W-1:0] KEY_LEFT  = 16'h0004;
  localparam logic [KEY_W-1:0] KEY_RIGHT = 16'h0007;
  localparam logic [KEY_W-1:0] KEY_ROT   = 16'h001A;
  localparam logic [KEY_W-1:0] KEY_DROP  = 16'h0016;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SHAPE,
    ST_SPAWN,
    ST_FALL,
    ST_LOCK,
    ST_GAME_OVER
  } state_e;

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [ROT_W-1:0]   rot;
    logic [SHAPE_W-1:0] shape;
  } pose_t;

endpackage

// File: rtl/piece_drop_ctrl_if.sv
// Bundle between the piece controller and its environment (board, generator,
// keyboard). master = environment side, slave = controller side.
//   tick, shape_num, keycode, collide_*  : environment -> controller
//   piece_*, touchdown, lock_we, game_over: controller -> environment
interface piece_drop_ctrl_if;
  import tetris_pkg::*;

  logic                tick;
  logic [SHAPE_W-1:0]  shape_num;
  logic [KEY_W-1:0]    keycode;
  logic                collide_down;
  logic                collide_left;
  logic                collide_right;
  logic                collide_rot;
  logic                collide_here;
  logic [X_W-1:0]      piece_x;
  logic [Y_W-1:0]      piece_y;
  logic [ROT_W-1:0]    piece_rot;
  logic [SHAPE_W-1:0]  piece_shape;
  logic                touchdown;
  logic                lock_we;
  logic                game_over;

  modport master (
    output tick, shape_num, keycode,
    output collide_down, collide_left, collide_right, collide_rot, collide_here,
    input  piece_x, piece_y, piece_rot, piece_shape,
    input  touchdown, lock_we, game_over
  );

  modport slave (
    input  tick, shape_num, keycode,
    input  collide_down, collide_left, collide_right, collide_rot, collide_here,
    output piece_x, piece_y, piece_rot, piece_shape,
    output touchdown, lock_we, game_over
  );

endinterface

// File: rtl/key_edge.sv
// Keyboard press detector: remembers last cycle's keycode and flags a
// one-cycle press when keycode changes to one of the four action codes.
//   Clk, Reset : clock, synchronous active-high reset (clears key history)
//   keycode    : current keyboard code
//   *_c        : combinational press pulses for left/right/rotate/soft drop
module key_edge
  import tetris_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic [KEY_W-1:0] keycode,
  output logic             left_c,
  output logic             right_c,
  output logic             rot_c,
  output logic             drop_c
);

  logic [KEY_W-1:0] key_prev_q;
  logic [KEY_W-1:0] key_prev_d;

  always_comb key_prev_d = keycode;

  always_ff @(posedge Clk) begin
    if (Reset) key_prev_q <= '0;
    else       key_prev_q <= key_prev_d;
  end

  // A held key yields only its first cycle; history tracks every cycle so
  // a key held across a state change never re-fires later.
  always_comb begin
    left_c  = (keycode == KEY_LEFT)  && (key_prev_q != KEY_LEFT);
    right_c = (keycode == KEY_RIGHT) && (key_prev_q != KEY_RIGHT);
    rot_c   = (keycode == KEY_ROT)   && (key_prev_q != KEY_ROT);
    drop_c  = (keycode == KEY_DROP)  && (key_prev_q != KEY_DROP);
  end

endmodule

// File: rtl/piece_drop_ctrl.sv
// Active-piece controller: waits for the generator, spawns a piece, moves it
// under gravity ticks and key presses, locks it on touchdown and detects
// game over when a fresh spawn already overlaps the board.
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : slave side of piece_drop_ctrl_if (inputs from board/keys,
//                registered pose, touchdown/lock_we strobe, game_over flag)
module piece_drop_ctrl
  import tetris_pkg::*;
#(
  parameter int unsigned SPAWN_X    = 4,
  parameter int unsigned SPAWN_Y    = 0,
  parameter int unsigned SHAPE_WAIT = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  piece_drop_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = (SHAPE_WAIT < 1) ? 1 : $clog2(SHAPE_WAIT + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             first_q, first_d;
  pose_t            pose_q, pose_d;
  logic             td_q, td_d;
  logic             go_q, go_d;

  logic left_c, right_c, rot_c, drop_c;
  logic step_req_c, lat_req_c, fall_step_c;

  key_edge u_key_edge (
    .Clk     (Clk),
    .Reset   (Reset),
    .keycode (bus.keycode),
    .left_c  (left_c),
    .right_c (right_c),
    .rot_c   (rot_c),
    .drop_c  (drop_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    first_d     = 1'b0;
    pose_d      = pose_q;
    td_d        = 1'b0;
    go_d        = go_q;
    fall_step_c = 1'b0;
    step_req_c  = bus.tick | drop_c;
    lat_req_c   = left_c | right_c | rot_c;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.tick) begin
          state_d = ST_WAIT_SHAPE;
          cnt_d   = '0;
        end
      end

      ST_WAIT_SHAPE: begin
        // Count saturates at SHAPE_WAIT while the generator has no shape.
        if (cnt_q >= CNT_W'(SHAPE_WAIT)) begin
          if (bus.shape_num != '0) state_d = ST_SPAWN;
        end else if (bus.tick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SPAWN: begin
        pose_d.x     = X_W'(SPAWN_X);
        pose_d.y     = Y_W'(SPAWN_Y);
        pose_d.rot   = '0;
        pose_d.shape = bus.shape_num;
        pend_d       = 1'b0;
        first_d      = 1'b1;
        state_d      = ST_FALL;
      end

      ST_FALL: begin
        if (first_q && bus.collide_here) begin
          state_d = ST_GAME_OVER;
          go_d    = 1'b1;
          pend_d  = 1'b0;
        end else begin
          // A lateral key wins the cycle; a coincident gravity step is
          // parked in the one-deep pending flag (a second one is lost).
          if (lat_req_c) begin
            if (left_c && !bus.collide_left)   pose_d.x   = pose_q.x - X_W'(1);
            if (right_c && !bus.collide_right) pose_d.x   = pose_q.x + X_W'(1);
            if (rot_c && !bus.collide_rot)     pose_d.rot = pose_q.rot + ROT_W'(1);
            if (step_req_c) pend_d = 1'b1;
          end else if (pend_q || step_req_c) begin
            pend_d      = 1'b0;
            fall_step_c = 1'b1;
          end

          if (fall_step_c) begin
            if (bus.collide_down) begin
              state_d = ST_LOCK;
              td_d    = 1'b1;
              pend_d  = 1'b0;
            end else begin
              pose_d.y = pose_q.y + Y_W'(1);
            end
          end
        end
      end

      ST_LOCK: begin
        state_d = ST_WAIT_SHAPE;
        cnt_d   = '0;
      end

      ST_GAME_OVER: begin
        go_d = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      first_q     <= 1'b0;
      pose_q.x     <= X_W'(SPAWN_X);
      pose_q.y     <= Y_W'(SPAWN_Y);
      pose_q.rot   <= '0;
      pose_q.shape <= '0;
      td_q        <= 1'b0;
      go_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      first_q <= first_d;
      pose_q  <= pose_d;
      td_q    <= td_d;
      go_q    <= go_d;
    end
  end

  // touchdown and lock_we share one flop so they are always coincident.
  assign bus.piece_x     = pose_q.x;
  assign bus.piece_y     = pose_q.y;
  assign bus.piece_rot   = pose_q.rot;
  assign bus.piece_shape = pose_q.shape;
  assign bus.touchdown   = td_q;
  assign bus.lock_we     = td_q;
  assign bus.game_over   = go_q;

endmodule

// File: tb/tb_piece_drop_ctrl.sv
// Scoreboard bench for piece_drop_ctrl: stimulus pushes expected pose/flag
// snapshots, a negedge monitor pops and compares them and also watches the
// touchdown strobe for back-to-back pulses.
module tb_piece_drop_ctrl;

  logic Clk;
  logic Reset;

  piece_drop_ctrl_if bus ();

  piece_drop_ctrl #(
    .SPAWN_X    (4),
    .SPAWN_Y    (0),
    .SHAPE_WAIT (4)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic [3:0] x;
    logic [4:0] y;
    logic [1:0] rot;
    logic [2:0] shape;
    logic       td;
    logic       go;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   td_count = 0;
  logic td_prev  = 1'b0;

  // Monitor: compare the DUT against the oldest queued expectation.
  always @(negedge Clk) begin
    exp_t e;
    if (bus.touchdown) begin
      n_checks++;
      if (td_prev) begin
        n_fail++;
        $display("FAIL td_consecutive: touchdown high two cycles in a row at %0t", $time);
      end
      if (!td_prev) td_count++;
    end
    td_prev = bus.touchdown;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({bus.piece_x, bus.piece_y, bus.piece_rot, bus.piece_shape,
           bus.touchdown, bus.lock_we, bus.game_over} !==
          {e.x, e.y, e.rot, e.shape, e.td, e.td, e.go}) begin
        n_fail++;
        $display("FAIL %s: got x=%0d y=%0d rot=%0d shape=%0d td=%0b we=%0b go=%0b, expected x=%0d y=%0d rot=%0d shape=%0d td=%0b we=%0b go=%0b",
                 e.name, bus.piece_x, bus.piece_y, bus.piece_rot, bus.piece_shape,
                 bus.touchdown, bus.lock_we, bus.game_over,
                 e.x, e.y, e.rot, e.shape, e.td, e.td, e.go);
      end
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic step(input logic t);
    bus.tick = t;
    cyc();
    bus.tick = 1'b0;
  endtask

  task automatic push_exp(input string n, input int x, input int y, input int r,
                          input int s, input int td, input int go);
    exp_t e;
    e.name  = n;
    e.x     = 4'(x);
    e.y     = 5'(y);
    e.rot   = 2'(r);
    e.shape = 3'(s);
    e.td    = 1'(td);
    e.go    = 1'(go);
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset             = 1'b1;
    bus.tick          = 1'b0;
    bus.shape_num     = 3'd0;
    bus.keycode       = 16'h0000;
    bus.collide_down  = 1'b0;
    bus.collide_left  = 1'b0;
    bus.collide_right = 1'b0;
    bus.collide_rot   = 1'b0;
    bus.collide_here  = 1'b0;

    cyc();
    cyc();
    push_exp("reset", 4, 0, 0, 0, 0, 0);
    Reset = 1'b0;

    // Game 1: leave IDLE, wait with no shape available, then spawn shape 3.
    step(1'b1);
    for (int i = 0; i < 4; i++) step(1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    push_exp("shape0_hold", 4, 0, 0, 0, 0, 0);
    bus.shape_num = 3'd3;
    step(1'b0);
    push_exp("pre_spawn", 4, 0, 0, 0, 0, 0);
    step(1'b0);
    push_exp("spawn", 4, 0, 0, 3, 0, 0);

    // Gravity.
    step(1'b1); push_exp("fall_y1", 4, 1, 0, 3, 0, 0);
    step(1'b1); push_exp("fall_y2", 4, 2, 0, 3, 0, 0);
    step(1'b1); push_exp("fall_y3", 4, 3, 0, 3, 0, 0);

    // Held left moves once; blocked left is discarded.
    bus.keycode = 16'h0004;
    step(1'b0);
    push_exp("left_press", 3, 3, 0, 3, 0, 0);
    for (int i = 0; i < 9; i++) step(1'b0);
    push_exp("left_held", 3, 3, 0, 3, 0, 0);
    bus.keycode = 16'h0000;
    step(1'b0);
    bus.collide_left = 1'b1;
    bus.keycode = 16'h0004;
    step(1'b0);
    push_exp("left_blocked", 3, 3, 0, 3, 0, 0);
    bus.keycode = 16'h0000;
    bus.collide_left = 1'b0;
    step(1'b0);

    // Rotation wraps 3 -> 0.
    for (int i = 1; i <= 4; i++) begin
      bus.keycode = 16'h001A;
      step(1'b0);
      push_exp($sformatf("rot_%0d", i), 3, 3, i % 4, 3, 0, 0);
      bus.keycode = 16'h0000;
      step(1'b0);
    end

    // Key and tick together: key now, tick deferred one cycle.
    bus.keycode = 16'h0007;
    step(1'b1);
    push_exp("tick_right_key", 4, 3, 0, 3, 0, 0);
    step(1'b0);
    push_exp("tick_right_pend", 4, 4, 0, 3, 0, 0);
    bus.keycode = 16'h0000;
    step(1'b0);

    // A tick arriving while one is pending is dropped.
    bus.keycode = 16'h0004;
    step(1'b1);
    push_exp("tick_left_key", 3, 4, 0, 3, 0, 0);
    step(1'b1);
    push_exp("pend_applied", 3, 5, 0, 3, 0, 0);
    step(1'b0);
    push_exp("tick_dropped", 3, 5, 0, 3, 0, 0);

    // Soft drop acts as a tick.
    bus.keycode = 16'h0016;
    step(1'b0);
    push_exp("soft_drop", 3, 6, 0, 3, 0, 0);
    bus.keycode = 16'h0000;
    step(1'b0);

    // Lock: single-cycle touchdown.
    bus.collide_down = 1'b1;
    step(1'b1);
    push_exp("lock", 3, 6, 0, 3, 1, 0);
    bus.collide_down = 1'b0;
    step(1'b0);
    push_exp("lock_end", 3, 6, 0, 3, 0, 0);

    // Keys outside FALL are ignored.
    bus.keycode = 16'h0004;
    step(1'b0);
    push_exp("key_outside_fall", 3, 6, 0, 3, 0, 0);
    bus.keycode = 16'h0000;

    // Game 2: spawn onto an occupied board -> game over.
    bus.shape_num = 3'd5;
    for (int i = 0; i < 4; i++) step(1'b1);
    step(1'b0);
    bus.collide_here = 1'b1;
    step(1'b0);
    push_exp("spawn2", 4, 0, 0, 5, 0, 0);
    step(1'b0);
    push_exp("game_over", 4, 0, 0, 5, 0, 1);
    bus.keycode = 16'h0007;
    step(1'b1);
    push_exp("go_tick_right", 4, 0, 0, 5, 0, 1);
    bus.keycode = 16'h001A;
    step(1'b1);
    push_exp("go_tick_rot", 4, 0, 0, 5, 0, 1);
    bus.keycode = 16'h0000;
    bus.collide_here = 1'b0;
    step(1'b0);
    push_exp("go_sticky", 4, 0, 0, 5, 0, 1);

    Reset = 1'b1;
    step(1'b0);
    push_exp("reset_clears_go", 4, 0, 0, 0, 0, 0);
    Reset = 1'b0;

    // Game 3: reset during LOCK suppresses any further strobe.
    step(1'b1);
    bus.shape_num = 3'd2;
    for (int i = 0; i < 4; i++) step(1'b1);
    step(1'b0);
    step(1'b0);
    push_exp("spawn3", 4, 0, 0, 2, 0, 0);
    bus.collide_down = 1'b1;
    step(1'b1);
    push_exp("lock3", 4, 0, 0, 2, 1, 0);
    Reset = 1'b1;
    step(1'b0);
    push_exp("reset_mid_lock", 4, 0, 0, 0, 0, 0);
    Reset = 1'b0;
    bus.collide_down = 1'b0;
    step(1'b0);
    push_exp("after_reset_lock", 4, 0, 0, 0, 0, 0);

    step(1'b0);
    step(1'b0);

    n_checks++;
    if (td_count != 2) begin
      n_fail++;
      $display("FAIL td_count: got %0d touchdown pulses, expected 2", td_count);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d unchecked entries, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piece_drop_ctrl.md
PIECE_DROP_CTRL -- requirements
Module: piece_drop_ctrl

Interface
REQ-001 SHALL have parameter SPAWN_X, default 4, spawn column of the active piece.
REQ-002 SHALL have parameter SPAWN_Y, default 0, spawn row of the active piece.
REQ-003 SHALL have parameter SHAPE_WAIT, default 4, ticks waited after touchdown before sampling shape_num.
REQ-004 SHALL have ports: Clk  in  1  system clock; one clock; reset is synchronous and active-high.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 tick  in  1  gravity step; single-Clk pulse per slow-clock period.
REQ-007 shape_num  in  3  next shape from the piece generator; 1..7 valid, 0 invalid.
REQ-008 keycode  in  16  current keyboard code; 0x0000 means no key.
REQ-009 collide_down / collide_left / collide_right / collide_rot  in  1 each  board reports that moving down, left, right or rotating from the current pose collides.
REQ-010 collide_here  in  1  current pose overlaps the board.
REQ-011 piece_x  out  4; piece_y  out  5; piece_rot  out  2; piece_shape  out  3  active piece pose.
REQ-012 touchdown  out  1  one-cycle pulse when the piece locks; feeds the generator.
REQ-013 lock_we  out  1  one-cycle board merge strobe, coincident with touchdown.
REQ-014 game_over  out  1  sticky game-over flag.

Function
REQ-015 States: IDLE, WAIT_SHAPE, SPAWN, FALL, LOCK, GAME_OVER.
REQ-016 IDLE -> WAIT_SHAPE on the first tick after reset; wait counter cleared.
REQ-017 WAIT_SHAPE counts ticks; once count reaches SHAPE_WAIT and shape_num != 0 -> SPAWN; shape_num == 0 holds state, count saturates.
REQ-018 SPAWN lasts one Clk: piece_shape <= shape_num, piece_x <= SPAWN_X, piece_y <= SPAWN_Y, piece_rot <= 0; -> FALL.
REQ-019 In the first FALL cycle after SPAWN, collide_here = 1 -> GAME_OVER.
REQ-020 FALL, on tick: collide_down = 0 -> piece_y + 1; collide_down = 1 -> LOCK.
REQ-021 Key actions act once per press; a press is keycode changing to the action code from any other value, detected by key_edge.
REQ-022 Key codes: 0x0004 left, 0x0007 right, 0x001A rotate, 0x0016 soft drop.
REQ-023 Left/right/rotate apply only when the matching collide input is 0; otherwise the press is discarded.
REQ-024 piece_rot wraps 3 -> 0.
REQ-025 Soft drop behaves exactly as a tick.
REQ-026 Simultaneous key press and tick: the key action is applied this cycle and the tick is held in a one-deep pending flag, then applied next cycle; a further tick while pending is dropped.
REQ-027 Keys and ticks outside FALL are ignored, except ticks counted in IDLE/WAIT_SHAPE; pending clears on leaving FALL.
REQ-028 LOCK lasts one Clk: touchdown = lock_we = 1; -> WAIT_SHAPE, counter cleared.
REQ-029 GAME_OVER is absorbing until Reset; game_over = 1; pose frozen.
REQ-030 touchdown and lock_we SHALL never be high for two consecutive cycles.

Reset
REQ-031 On Reset: state IDLE; piece_x = SPAWN_X, piece_y = SPAWN_Y, piece_rot = 0, piece_shape = 0; touchdown = lock_we = game_over = 0; counter, pending and key history cleared.
REQ-032 Reset in any state, mid-fall or mid-LOCK, takes effect the next Clk edge; no partial touchdown pulse follows.

Structure
REQ-033 tetris_pkg SHALL hold the key-code constants, the state enum, and the X/Y/rotation/shape width constants.
REQ-034 One sub-module, key_edge: registers keycode and outputs one-cycle press pulses for the four action codes.

Verification
REQ-035 Reset, tick, shape_num = 3, 4 more ticks -> SPAWN; piece_shape = 3, x = 4, y = 0, rot = 0.
REQ-036 FALL, collide_down = 0, 3 ticks -> piece_y = 3; next tick with collide_down = 1 -> touchdown and lock_we high exactly 1 cycle.
REQ-037 keycode 0x0004 held 10 cycles, collide_left = 0 -> piece_x decrements by exactly 1; with collide_left = 1 -> x unchanged.
REQ-038 Rotate pressed 4 times (0x001A / 0x0000 alternating) -> rot 1, 2, 3, 0.
REQ-039 Tick and 0x0007 press in the same cycle -> x + 1 this cycle, y + 1 the next cycle.
REQ-040 collide_here = 1 on the first FALL cycle -> game_over = 1, persists through ticks and keys; cleared only by Reset.
